// File: rtl/deagc_divider.sv
// De-normalises an AGC-scaled complex sample by dividing each component by the applied gain.
// Two restoring dividers run in lockstep, followed by a rounding, sign and saturation stage.
module deagc_divider #(
    parameter int SAMPLE_WH = 16,
    parameter int SAMPLE_FR = 15,
    parameter int GAIN_WH   = 16,
    parameter int GAIN_FR   = 8
) (
    input  logic                 clk,
    input  logic                 nrst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [SAMPLE_WH-1:0] in_real,
    input  logic [SAMPLE_WH-1:0] in_imag,
    input  logic [GAIN_WH-1:0]   gain,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [SAMPLE_WH-1:0] out_real,
    output logic [SAMPLE_WH-1:0] out_imag,
    output logic                 div0
);

    localparam int N  = SAMPLE_WH + GAIN_FR + 1;
    localparam int CW = $clog2(N);

    localparam logic [N-1:0]         POS_LIM = N'((64'd1 << (SAMPLE_WH - 1)) - 64'd1);
    localparam logic [N-1:0]         NEG_LIM = N'(64'd1 << (SAMPLE_WH - 1));
    localparam logic [SAMPLE_WH-1:0] SAT_POS = {1'b0, {(SAMPLE_WH-1){1'b1}}};
    localparam logic [SAMPLE_WH-1:0] SAT_NEG = {1'b1, {(SAMPLE_WH-1){1'b0}}};
    localparam logic [SAMPLE_WH-1:0] ONE     = SAMPLE_WH'(1);
    localparam logic [CW-1:0]        LAST    = CW'(N - 1);

    // Output format equals input format, so only the Q1.x sample layout is supported.
    if (SAMPLE_FR != SAMPLE_WH - 1) begin : g_fmt_check
        $error("deagc_divider: samples must be Q1.%0d", SAMPLE_WH - 1);
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DIV  = 2'd1,
        S_RND  = 2'd2,
        S_OUT  = 2'd3
    } state_t;

    state_t              state_reg;
    state_t              state_next;
    logic [CW-1:0]       cnt_reg;
    logic [GAIN_WH-1:0]  gain_reg;
    logic                gain_zero_reg;
    logic                div0_reg;
    logic                accept;

    assign accept = (state_reg == S_IDLE) && in_valid;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: if (in_valid) state_next = (gain == '0) ? S_RND : S_DIV;
            S_DIV:  if (cnt_reg == LAST) state_next = S_RND;
            S_RND:  state_next = S_OUT;
            S_OUT:  if (out_ready) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_reg == S_IDLE);
        out_valid = (state_reg == S_OUT);
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            cnt_reg       <= '0;
            gain_reg      <= '0;
            gain_zero_reg <= 1'b0;
            div0_reg      <= 1'b0;
        end else begin
            if (accept) begin
                gain_reg      <= gain;
                gain_zero_reg <= (gain == '0);
            end
            if (state_reg == S_DIV) begin
                cnt_reg <= (cnt_reg == LAST) ? '0 : cnt_reg + CW'(1);
            end
            if (state_reg == S_RND) begin
                div0_reg <= gain_zero_reg;
            end
        end
    end

    genvar gi;
    for (gi = 0; gi < 2; gi++) begin : g_lane
        logic [SAMPLE_WH-1:0] x;
        logic [SAMPLE_WH-1:0] abs_x;
        logic [GAIN_WH:0]     shifted;
        logic                 fits;
        logic [N:0]           q_inc;
        logic [N-1:0]         mag;
        logic [SAMPLE_WH-1:0] res_next;
        logic                 sign_reg;
        logic                 nz_reg;
        logic [GAIN_WH-1:0]   rem_reg;
        logic [N-1:0]         quo_reg;
        logic [SAMPLE_WH-1:0] res_reg;

        if (gi == 0) begin : g_re
            assign x = in_real;
        end else begin : g_im
            assign x = in_imag;
        end

        // The most negative code maps to its own bit pattern, read as an unsigned magnitude.
        assign abs_x   = x[SAMPLE_WH-1] ? (~x + ONE) : x;
        assign shifted = {rem_reg, quo_reg[N-1]};
        assign fits    = (shifted >= {1'b0, gain_reg});
        assign q_inc   = {1'b0, quo_reg} + (N+1)'(1);
        assign mag     = N'(q_inc >> 1);

        always_comb begin
            res_next = '0;
            if (!nz_reg) begin
                res_next = '0;
            end else if (gain_zero_reg) begin
                res_next = sign_reg ? SAT_NEG : SAT_POS;
            end else if (!sign_reg) begin
                res_next = (mag > POS_LIM) ? SAT_POS : mag[SAMPLE_WH-1:0];
            end else begin
                res_next = (mag > NEG_LIM) ? SAT_NEG : (~mag[SAMPLE_WH-1:0] + ONE);
            end
        end

        always_ff @(posedge clk or negedge nrst) begin
            if (!nrst) begin
                sign_reg <= 1'b0;
                nz_reg   <= 1'b0;
                rem_reg  <= '0;
                quo_reg  <= '0;
                res_reg  <= '0;
            end else begin
                if (accept) begin
                    sign_reg <= x[SAMPLE_WH-1];
                    nz_reg   <= (x != '0);
                    rem_reg  <= '0;
                    quo_reg  <= {abs_x, {(GAIN_FR+1){1'b0}}};
                end else if (state_reg == S_DIV) begin
                    // Dividend bits shift out of the top while quotient bits shift in at the bottom.
                    if (fits) begin
                        rem_reg <= GAIN_WH'(shifted - {1'b0, gain_reg});
                        quo_reg <= {quo_reg[N-2:0], 1'b1};
                    end else begin
                        rem_reg <= GAIN_WH'(shifted);
                        quo_reg <= {quo_reg[N-2:0], 1'b0};
                    end
                end
                if (state_reg == S_RND) begin
                    res_reg <= res_next;
                end
            end
        end
    end

    assign out_real = g_lane[0].res_reg;
    assign out_imag = g_lane[1].res_reg;
    assign div0     = div0_reg;

endmodule

// File: tb/tb_deagc_divider.sv
// Directed bench for deagc_divider: hand-computed vectors for rounding, saturation,
// divide-by-zero, backpressure and mid-operation reset.
module tb_deagc_divider;

    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_real = '0;
    logic [15:0] in_imag = '0;
    logic [15:0] gain = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_real;
    logic [15:0] out_imag;
    logic        div0;

    int n_cmp = 0;
    int n_err = 0;

    deagc_divider dut (
        .clk       (clk),
        .nrst      (nrst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_real   (in_real),
        .in_imag   (in_imag),
        .gain      (gain),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_real  (out_real),
        .out_imag  (out_imag),
        .div0      (div0)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One full transaction: accept, measure latency, check result, optional stall, release.
    task automatic run(input string tag, input logic [15:0] g, input logic [15:0] re,
                       input logic [15:0] im, input logic [15:0] er, input logic [15:0] ei,
                       input logic ed, input int exp_lat, input int hold);
        int lat;
        @(negedge clk);
        check({tag, ".ready_idle"}, in_ready, 1);
        in_valid = 1'b1;
        gain     = g;
        in_real  = re;
        in_imag  = im;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_real  = 16'h5A5A;
        in_imag  = 16'hA5A5;
        gain     = 16'h0001;
        check({tag, ".ready_busy"}, in_ready, 0);
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!out_valid && lat < 60);
        check({tag, ".latency"}, lat, exp_lat);
        check({tag, ".out_real"}, out_real, er);
        check({tag, ".out_imag"}, out_imag, ei);
        check({tag, ".div0"}, div0, ed);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check({tag, ".stall_valid"}, out_valid, 1);
            check({tag, ".stall_ready"}, in_ready, 0);
            check({tag, ".stall_real"}, out_real, er);
            check({tag, ".stall_imag"}, out_imag, ei);
            check({tag, ".stall_div0"}, div0, ed);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, ".drop_valid"}, out_valid, 0);
        check({tag, ".rise_ready"}, in_ready, 1);
        check({tag, ".keep_real"}, out_real, er);
        check({tag, ".keep_imag"}, out_imag, ei);
        check({tag, ".keep_div0"}, div0, ed);
        $display("txn %s gain=%h in=(%h,%h) out=(%h,%h) div0=%b lat=%0d",
                 tag, g, re, im, out_real, out_imag, div0, lat);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("reset.in_ready", in_ready, 1);
        check("reset.out_valid", out_valid, 0);
        check("reset.out_real", out_real, 0);
        check("reset.out_imag", out_imag, 0);
        check("reset.div0", div0, 0);
        @(negedge clk);
        nrst = 1'b1;

        run("unity",    16'h0100, 16'h4000, 16'hC000, 16'h4000, 16'hC000, 1'b0, 26, 0);
        run("gain2",    16'h0200, 16'h2000, 16'hFFFF, 16'h1000, 16'hFFFF, 1'b0, 26, 0);
        run("sat_half", 16'h0080, 16'h6000, 16'hA000, 16'h7FFF, 16'h8000, 1'b0, 26, 10);
        run("sat_edge", 16'h0100, 16'h8000, 16'h7FFF, 16'h8000, 16'h7FFF, 1'b0, 26, 0);
        run("g1p5",     16'h0180, 16'h0003, 16'hFFFF, 16'h0002, 16'hFFFF, 1'b0, 26, 0);
        run("g3_small", 16'h0300, 16'h0001, 16'hFFFF, 16'h0000, 16'h0000, 1'b0, 26, 0);
        run("gmax",     16'hFFFF, 16'h7FFF, 16'h3000, 16'h0080, 16'h0030, 1'b0, 26, 0);
        run("div0_pos", 16'h0000, 16'h1234, 16'h0000, 16'h7FFF, 16'h0000, 1'b1, 1, 0);
        run("div0_clr", 16'h0100, 16'h1234, 16'h0000, 16'h1234, 16'h0000, 1'b0, 26, 0);
        run("div0_neg", 16'h0000, 16'hFFFF, 16'h8000, 16'h8000, 16'h8000, 1'b1, 1, 0);

        // Abort a division partway through its iterations.
        @(negedge clk);
        in_valid = 1'b1;
        gain     = 16'h0100;
        in_real  = 16'h4000;
        in_imag  = 16'hC000;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (12) @(posedge clk);
        #2;
        nrst = 1'b0;
        #1;
        check("midrst.in_ready", in_ready, 1);
        check("midrst.out_valid", out_valid, 0);
        check("midrst.out_real", out_real, 0);
        check("midrst.out_imag", out_imag, 0);
        check("midrst.div0", div0, 0);
        $display("txn midrst aborted at iteration 12");
        @(negedge clk);
        nrst = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        check("midrst.no_output", out_valid, 0);
        check("midrst.idle", in_ready, 1);

        run("post_rst", 16'h0100, 16'h4000, 16'hC000, 16'h4000, 16'hC000, 1'b0, 26, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
